io_stall_controller: RTL and testbench
======================================

// Module: io_stall_controller
// PURPOSE
//  MMIO peripheral controller between the single-cycle core's IORead/IOWrite decode and the board I/O.
//  Owns the LED register, non-blocking and blocking switch reads, and the confirm-button handshake.
//  A blocking switch read (ecall-style input) freezes the core via stall until a debounced confirm press.
//  Sits beside data RAM; its io_rdata feeds the MemorIOToReg writeback mux.
// PARAMETERS
//  DEBOUNCE_CYCLES  20  consecutive stable cycles before the debounced button level changes (board: 2_000_000)
//  SW_WIDTH         16  switch bank width
//  LED_WIDTH        16  LED bank width
// PORTS
//  clk           in   1         system clock
//  rst           in   1         synchronous, active-high reset
//  io_read_req   in   1         IORead from the decoder
//  io_write_req  in   1         IOWrite from the decoder
//  io_addr       in   32        ALU result (MMIO address)
//  io_wdata      in   32        store data (rs2)
//  confirm_btn   in   1         raw, asynchronous, bouncing button
//  switches      in   SW_WIDTH  raw switch levels
//  stall         out  1         1 = hold PC and suppress register writeback
//  io_rdata      out  32        read data to the writeback mux
//  led           out  LED_WIDTH LED register
//  wait_led      out  1         1 while waiting for confirm
// BEHAVIOUR
//  Address map:
//   - 0xFFFFFC60: LED write.
//   - 0xFFFFFC70: blocking switch read.
//   - 0xFFFFFC74: non-blocking switch read.
//   - Others: reads return 0, writes are ignored, no stall.
//  Reset: state IDLE; led, sw_latch, debounce counter and debounced level all 0; stall=0, io_rdata=0, wait_led=0.
//   - rst wins over every other event.
//  Button path:
//   - 2-FF synchronizer on confirm_btn and on switches.
//   - Debounce counter counts while sync_btn != deb_level, clears when they are equal.
//   - deb_level toggles when the count reaches DEBOUNCE_CYCLES.
//   - press = one-cycle pulse on the 0->1 edge of deb_level.
//  LED: io_write_req && addr==0xFFFFFC60 -> led <= io_wdata[LED_WIDTH-1:0] at the clock edge. Never stalls.
//  Non-blocking read: io_rdata = zero-extended sync switches, combinational, no stall.
//  FSM (IDLE, WAIT_PRESS, DONE):
//   - IDLE:
//     - blocking read -> stall=1 combinationally in the same cycle; next state WAIT_PRESS.
//     - A press in this same cycle is NOT accepted.
//   - WAIT_PRESS:
//     - stall=1, wait_led=1.
//     - press -> sw_latch <= sync switches; next state DONE.
//     - io_read_req dropped -> next state IDLE (defensive path).
//   - DONE:
//     - stall=0, io_rdata=sw_latch for exactly one cycle (the core writes back here).
//     - Next state IDLE.
//  Presses outside WAIT_PRESS are discarded, never queued.
//  A button already held at entry needs release plus re-press (edge-triggered).
//  Core contract: io_addr and the request signals are held stable while stall=1.
//  Simultaneous read and write requests are undefined (the decoder never issues both).
//  Reset mid-WAIT_PRESS: stall=0 from the cycle after rst; the pending read is abandoned.
// STRUCTURE
//  io_map_pkg:
//   - Address localparams (LED_ADDR, SW_BLOCK_ADDR, SW_NB_ADDR).
//   - FSM state encoding (2-bit).
//  Sub-module btn_debounce (synchronizer + counter + press pulse), parameterised by DEBOUNCE_CYCLES.
//  Top: address decode, FSM, LED/sw_latch registers, read mux.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset: rst=1 for 2 cycles after arbitrary activity -> led=0, stall=0, io_rdata=0, wait_led=0.
//  2. LED write to 0xFFFFFC60, wdata=0x0000A5A5 -> led=16'hA5A5 after the edge; stall=0 throughout.
//  3. Blocking read of 0xFFFFFC70, switches=0x1234:
//     - stall=1 in the entry cycle.
//     - Button held clean for 8 cycles -> stall drops within 2+4+2 cycles.
//     - io_rdata=0x00001234 for one cycle, then IDLE.
//  4. Bounce: during a blocking read, btn toggles every 2 cycles for 12 cycles then returns low -> no press; stall stays 1.
//  5. Held button: btn high before the blocking read -> no acceptance; release 6 cycles, re-press 6 cycles -> completes.
//  6. rst during WAIT_PRESS -> stall=0 next cycle; a read of 0xFFFFFC80 returns 0 with stall=0.

Source files
------------

// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - MMIO address map and FSM encoding for the I/O stall controller
package io_map_pkg;

  localparam logic [31:0] LED_ADDR      = 32'hFFFF_FC60;
  localparam logic [31:0] SW_BLOCK_ADDR = 32'hFFFF_FC70;
  localparam logic [31:0] SW_NB_ADDR    = 32'hFFFF_FC74;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_PRESS = 2'd1,
    ST_DONE       = 2'd2
  } io_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - confirm button synchronizer, debouncer and press-edge pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          deb_level;
  logic          deb_level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      deb_level   <= 1'b0;
      deb_level_d <= 1'b0;
      cnt         <= '0;
    end else begin
      sync1       <= btn;
      sync2       <= sync1;
      deb_level_d <= deb_level;
      // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync2 != deb_level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_level <= ~deb_level;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = deb_level & ~deb_level_d;

endmodule

// File: rtl/io_stall_controller.sv
// rtl/io_stall_controller.sv - MMIO LED/switch controller with blocking confirm-button read
module io_stall_controller
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 io_read_req,
  input  logic                 io_write_req,
  input  logic [31:0]          io_addr,
  input  logic [31:0]          io_wdata,
  input  logic                 confirm_btn,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic                 stall,
  output logic [31:0]          io_rdata,
  output logic [LED_WIDTH-1:0] led,
  output logic                 wait_led
);

  io_state_t           state;
  logic [SW_WIDTH-1:0] sw_sync1;
  logic [SW_WIDTH-1:0] sw_sync2;
  logic [SW_WIDTH-1:0] sw_latch;
  logic                press;
  logic                blk_read;
  logic                nb_read;
  logic                led_write;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (confirm_btn),
    .press(press)
  );

  assign blk_read  = io_read_req  && (io_addr == SW_BLOCK_ADDR);
  assign nb_read   = io_read_req  && (io_addr == SW_NB_ADDR);
  assign led_write = io_write_req && (io_addr == LED_ADDR);

  generate
    if (LED_WIDTH < 32) begin : g_wdata_unused
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^io_wdata[31:LED_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      led      <= '0;
      sw_latch <= '0;
      sw_sync1 <= '0;
      sw_sync2 <= '0;
    end else begin
      sw_sync1 <= switches;
      sw_sync2 <= sw_sync1;
      if (led_write) begin
        led <= io_wdata[LED_WIDTH-1:0];
      end
      case (state)
        ST_IDLE: begin
          if (blk_read) begin
            state <= ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          // A dropped request abandons the read rather than waiting forever.
          if (!io_read_req) begin
            state <= ST_IDLE;
          end else if (press) begin
            sw_latch <= sw_sync2;
            state    <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Entry stall must be combinational so the core never retires the read early.
  assign stall    = ((state == ST_IDLE) && blk_read) || (state == ST_WAIT_PRESS);
  assign wait_led = (state == ST_WAIT_PRESS);

  always_comb begin
    io_rdata = 32'h0;
    if (state == ST_DONE) begin
      io_rdata = 32'(sw_latch);
    end else if (nb_read) begin
      io_rdata = 32'(sw_sync2);
    end
  end

endmodule

// File: tb/tb_io_stall_controller.sv
// tb/tb_io_stall_controller.sv - directed self-checking bench for io_stall_controller
module tb_io_stall_controller;

  logic        clk;
  logic        rst;
  logic        io_read_req;
  logic        io_write_req;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        confirm_btn;
  logic [15:0] switches;
  logic        stall;
  logic [31:0] io_rdata;
  logic [15:0] led;
  logic        wait_led;

  int n_compared;
  int n_mismatched;
  int n_cyc;

  io_stall_controller #(
    .DEBOUNCE_CYCLES(4),
    .SW_WIDTH       (16),
    .LED_WIDTH      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_read_req (io_read_req),
    .io_write_req(io_write_req),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .confirm_btn (confirm_btn),
    .switches    (switches),
    .stall       (stall),
    .io_rdata    (io_rdata),
    .led         (led),
    .wait_led    (wait_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_bus();
    io_read_req  = 1'b0;
    io_write_req = 1'b0;
    io_addr      = 32'h0;
    io_wdata     = 32'h0;
  endtask

  task automatic wait_stall_drop(input int budget, output int cycles);
    cycles = 0;
    while (stall && cycles < budget) begin
      step();
      settle();
      cycles++;
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b0;
    confirm_btn  = 1'b0;
    switches     = 16'h0;
    idle_bus();

    // 1. Reset after arbitrary activity
    rst = 1'b1;
    step();
    rst = 1'b0;
    io_write_req = 1'b1; io_addr = 32'hFFFF_FC60; io_wdata = 32'h0000_FFFF;
    switches = 16'h5A5A; confirm_btn = 1'b1;
    steps(3);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    idle_bus();
    confirm_btn = 1'b0;
    switches = 16'h0;
    settle();
    check("rst_led",      32'(led),      32'h0);
    check("rst_stall",    32'(stall),    32'h0);
    check("rst_rdata",    io_rdata,      32'h0);
    check("rst_wait_led", 32'(wait_led), 32'h0);
    steps(8);

    // 2. LED write, and write to an unmapped address is ignored
    io_write_req = 1'b1; io_addr = 32'hFFFF_FC60; io_wdata = 32'h0000_A5A5;
    settle();
    check("led_wr_stall", 32'(stall), 32'h0);
    step();
    io_addr = 32'hFFFF_FC64; io_wdata = 32'h0000_0000;
    settle();
    check("led_value", 32'(led), 32'h0000_A5A5);
    step();
    idle_bus();
    settle();
    check("led_unmapped_wr", 32'(led), 32'h0000_A5A5);

    // Non-blocking read after switches pass the synchronizer
    switches = 16'h1234;
    steps(3);
    io_read_req = 1'b1; io_addr = 32'hFFFF_FC74;
    settle();
    check("nb_rdata", io_rdata,   32'h0000_1234);
    check("nb_stall", 32'(stall), 32'h0);
    step();
    idle_bus();

    // 3. Blocking read with a clean press
    io_read_req = 1'b1; io_addr = 32'hFFFF_FC70;
    settle();
    check("blk_entry_stall", 32'(stall),    32'h1);
    check("blk_entry_wled",  32'(wait_led), 32'h0);
    step();
    settle();
    check("blk_wait_wled", 32'(wait_led), 32'h1);
    confirm_btn = 1'b1;
    wait_stall_drop(12, n_cyc);
    check("blk_press_latency", 32'(n_cyc), 32'd7);
    check("blk_done_rdata", io_rdata,      32'h0000_1234);
    check("blk_done_wled",  32'(wait_led), 32'h0);
    step();
    idle_bus();
    confirm_btn = 1'b0;
    settle();
    check("blk_after_rdata", io_rdata,   32'h0);
    check("blk_after_stall", 32'(stall), 32'h0);
    steps(10);

    // 4. Bouncing button never produces a press
    io_read_req = 1'b1; io_addr = 32'hFFFF_FC70;
    step();
    for (int i = 0; i < 12; i++) begin
      confirm_btn = ((i / 2) % 2) == 0;
      step();
    end
    confirm_btn = 1'b0;
    steps(8);
    settle();
    check("bounce_stall", 32'(stall),    32'h1);
    check("bounce_wled",  32'(wait_led), 32'h1);
    idle_bus();
    step();
    settle();
    check("drop_req_stall", 32'(stall),    32'h0);
    check("drop_req_wled",  32'(wait_led), 32'h0);
    steps(4);

    // 5. Button held before the read needs release and re-press
    switches = 16'hBEEF;
    confirm_btn = 1'b1;
    steps(10);
    io_read_req = 1'b1; io_addr = 32'hFFFF_FC70;
    step();
    steps(4);
    settle();
    check("held_no_accept", 32'(stall), 32'h1);
    confirm_btn = 1'b0;
    steps(6);
    settle();
    check("held_release_stall", 32'(stall), 32'h1);
    confirm_btn = 1'b1;
    wait_stall_drop(12, n_cyc);
    check("held_repress_latency", 32'(n_cyc), 32'd7);
    check("held_done_rdata",      io_rdata,   32'h0000_BEEF);
    step();
    idle_bus();
    confirm_btn = 1'b0;
    steps(10);

    // 6. Reset during WAIT_PRESS, then an unmapped read
    io_read_req = 1'b1; io_addr = 32'hFFFF_FC70;
    step();
    settle();
    check("pre_rst_stall", 32'(stall), 32'h1);
    rst = 1'b1;
    idle_bus();
    step();
    rst = 1'b0;
    settle();
    check("post_rst_stall", 32'(stall),    32'h0);
    check("post_rst_wled",  32'(wait_led), 32'h0);
    check("post_rst_led",   32'(led),      32'h0);
    io_read_req = 1'b1; io_addr = 32'hFFFF_FC80;
    settle();
    check("unmapped_rdata", io_rdata,   32'h0);
    check("unmapped_stall", 32'(stall), 32'h0);
    step();
    idle_bus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
